// File: rtl/fan_138_pkg.sv
// Shared constants and types for the fan_138 registered 1-to-8 demultiplexer.
package fan_138_pkg;

  localparam int FAN138_NUM_OUT = 8;
  localparam int FAN138_SEL_W   = 3;

  typedef logic [FAN138_NUM_OUT-1:0] oneHot_t;

endpackage : fan_138_pkg

// File: rtl/fan_138_dec.sv
// Combinational 3-to-8 decoder: converts a destination index into a one-hot enable.
module dec_3to8
  import fan_138_pkg::*;
(
  input  logic [FAN138_SEL_W-1:0] sel_i,
  output oneHot_t                 oneHot_o
);

  always_comb begin
    oneHot_o = oneHot_t'(1) << sel_i;
  end

endmodule : dec_3to8

// File: rtl/fan_138.sv
// Registered 1-to-8 fan-out: the selected output loads the input, all others clear to zero.
module fan_138
  import fan_138_pkg::*;
#(
  parameter int SIGNAL_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SIGNAL_WIDTH-1:0] in,
  input  logic [FAN138_SEL_W-1:0] selector,
  output logic [SIGNAL_WIDTH-1:0] out0,
  output logic [SIGNAL_WIDTH-1:0] out1,
  output logic [SIGNAL_WIDTH-1:0] out2,
  output logic [SIGNAL_WIDTH-1:0] out3,
  output logic [SIGNAL_WIDTH-1:0] out4,
  output logic [SIGNAL_WIDTH-1:0] out5,
  output logic [SIGNAL_WIDTH-1:0] out6,
  output logic [SIGNAL_WIDTH-1:0] out7
);

  oneHot_t                 selHot;
  logic [SIGNAL_WIDTH-1:0] outBus [FAN138_NUM_OUT];

  dec_3to8 u_dec (
    .sel_i    (selector),
    .oneHot_o (selHot)
  );

  // Unselected lanes load zero rather than holding, so stale data never lingers.
  for (genvar g = 0; g < FAN138_NUM_OUT; g++) begin : gLane
    logic [SIGNAL_WIDTH-1:0] out_d;
    logic [SIGNAL_WIDTH-1:0] out_q;

    always_comb begin
      out_d = selHot[g] ? in : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_q <= '0;
      end else begin
        out_q <= out_d;
      end
    end

    assign outBus[g] = out_q;
  end

  assign out0 = outBus[0];
  assign out1 = outBus[1];
  assign out2 = outBus[2];
  assign out3 = outBus[3];
  assign out4 = outBus[4];
  assign out5 = outBus[5];
  assign out6 = outBus[6];
  assign out7 = outBus[7];

endmodule : fan_138

// File: tb/tb_fan_138.sv
// Scoreboard bench for fan_138: an 8-bit and a 1-bit instance checked against a lane-array model.
module tb_fan_138;

  typedef struct {
    logic [7:0][7:0] exp8;
    logic [7:0]      exp1;
  } expItem_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in8 = '0;
  logic [2:0] sel8 = '0;
  logic       in1 = 1'b0;
  logic [2:0] sel1 = '0;

  logic [7:0] o8 [8];
  logic       o1 [8];
  logic [7:0][7:0] got8;
  logic [7:0]      got1;

  expItem_t   sbQueue [$];
  logic [7:0][7:0] lastExp8 = '0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fan_138 #(.SIGNAL_WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in(in8), .selector(sel8),
    .out0(o8[0]), .out1(o8[1]), .out2(o8[2]), .out3(o8[3]),
    .out4(o8[4]), .out5(o8[5]), .out6(o8[6]), .out7(o8[7])
  );

  fan_138 #(.SIGNAL_WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(in1), .selector(sel1),
    .out0(o1[0]), .out1(o1[1]), .out2(o1[2]), .out3(o1[3]),
    .out4(o1[4]), .out5(o1[5]), .out6(o1[6]), .out7(o1[7])
  );

  always_comb begin
    got8 = '0;
    got1 = '0;
    for (int k = 0; k < 8; k++) begin
      got8[k] = o8[k];
      got1[k] = o1[k];
    end
  end

  // Reference: a bank of eight lanes where only the indexed lane carries data.
  function automatic logic [7:0][7:0] model8(bit live, logic [7:0] d, int unsigned idx);
    logic [7:0][7:0] lanes;
    lanes = '0;
    if (live) lanes[idx] = d;
    return lanes;
  endfunction

  function automatic logic [7:0] model1(bit live, logic d, int unsigned idx);
    logic [7:0] lanes;
    lanes = '0;
    if (live) lanes[idx] = d;
    return lanes;
  endfunction

  task automatic checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(bit rst, logic [7:0] d8, int unsigned s8, logic d1, int unsigned s1);
    @(negedge clk);
    rst_n = rst;
    in8   = d8;
    sel8  = 3'(s8);
    in1   = d1;
    sel1  = 3'(s1);
  endtask

  always @(posedge clk) begin
    expItem_t item;
    item.exp8 = model8(rst_n, in8, sel8);
    item.exp1 = model1(rst_n, in1, sel1);
    sbQueue.push_back(item);
  end

  always @(posedge clk) begin
    expItem_t item;
    #1;
    if (sbQueue.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
    end else begin
      item = sbQueue.pop_front();
      checkOutput("lanes8", 64'(got8), 64'(item.exp8));
      checkOutput("lanes1", 64'(got1), 64'(item.exp1));
      lastExp8 = item.exp8;
    end
  end

  initial begin
    void'($urandom(33551));

    // Reset held with clock running and active-looking inputs.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'hFF, 3, 1'b1, 3);

    // Walk the selector with a fixed pattern.
    for (int s = 0; s < 8; s++) applyStimulus(1'b1, 8'hA5, s, 1'b1, 7 - s);

    // Latency: a mid-cycle change must not reach the output before the next edge.
    applyStimulus(1'b1, 8'h5A, 5, 1'b0, 0);
    applyStimulus(1'b1, 8'h3C, 5, 1'b0, 0);
    #1;
    checkOutput("latency_hold", 64'(got8[5]), 64'(lastExp8[5]));
    checkOutput("latency_prev", 64'(got8[5]), 64'(8'h5A));

    // Async reset between edges clears outputs without a clock.
    applyStimulus(1'b1, 8'h77, 2, 1'b1, 2);
    applyStimulus(1'b1, 8'h77, 2, 1'b1, 2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_clear8", 64'(got8), 64'(model8(1'b0, 8'h77, 2)));
    checkOutput("async_clear1", 64'(got1), 64'(model1(1'b0, 1'b1, 2)));
    applyStimulus(1'b0, 8'h77, 2, 1'b1, 2);
    applyStimulus(1'b1, 8'h00, 0, 1'b0, 0);

    // Randomised pairs for both widths.
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 8'($urandom), $urandom_range(7), 1'($urandom), $urandom_range(7));
    end

    // Reselect: the previously chosen lane must drop back to zero.
    applyStimulus(1'b1, 8'h11, 6, 1'b1, 6);
    applyStimulus(1'b1, 8'h22, 1, 1'b1, 1);
    applyStimulus(1'b1, 8'h00, 0, 1'b0, 0);

    @(posedge clk);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fan_138
